// File: rtl/audio_i2s_tx_pkg.sv
// Shared audio definitions: frame formats, frame geometry and the per-bit slot decode
// used by serial audio sinks.
package audio_i2s_tx_pkg;

   typedef enum logic [1:0] {
      FMT_I2S  = 2'd0,
      FMT_LJ   = 2'd1,
      FMT_RJ   = 2'd2,
      FMT_MUTE = 2'd3
   } audio_fmt_e;

   localparam int unsigned AUDIO_FRAME_CLKS = 512;
   localparam int unsigned AUDIO_SAMPLE_W   = 16;
   localparam int unsigned AUDIO_SLOT_BITS  = 32;

   // Bit of a 16-bit sample carried at slot bit index b (b=0 is the first bit after LRCK
   // changes). Each format is a 16-bit window starting at a format-specific offset.
   function automatic logic fmt_bit(input logic [15:0] s, input audio_fmt_e fmt,
                                    input logic [4:0] b);
      logic [4:0] first;
      logic [5:0] rel;
      logic       hit;
      unique case (fmt)
         FMT_I2S: first = 5'd1;
         FMT_LJ:  first = 5'd0;
         FMT_RJ:  first = 5'd16;
         default: first = 5'd0;
      endcase
      // Negative offsets wrap into rel[5], offsets past the word land in rel[4].
      rel = {1'b0, b} - {1'b0, first};
      hit = (fmt != FMT_MUTE) && (rel[5:4] == 2'b00);
      return hit & s[~rel[3:0]];
   endfunction

endpackage

// File: rtl/audio_frame_timer.sv
// Free-running audio frame timebase: one counter split into BCK phase, slot bit index and
// channel, plus frame start/end decodes.
module audio_frame_timer #(
   parameter int unsigned BCK_DIV_LOG2 = 3,
   parameter int unsigned SLOT_BITS    = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   output logic                         bck,
   output logic [$clog2(SLOT_BITS)-1:0] bit_idx,
   output logic                         chan,
   output logic                         frame_start,
   output logic                         frame_end
);

   localparam int unsigned BIT_W = $clog2(SLOT_BITS);
   localparam int unsigned CNT_W = BCK_DIV_LOG2 + BIT_W + 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Power-of-two frame length, so the natural wrap gives the 511 -> 0 rollover.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      bck         = cnt_q[BCK_DIV_LOG2-1];
      bit_idx     = cnt_q[BCK_DIV_LOG2 +: BIT_W];
      chan        = cnt_q[CNT_W-1];
      frame_start = (cnt_q == '0);
      frame_end   = &cnt_q;
   end

endmodule

// File: rtl/audio_i2s_tx.sv
// Stereo I2S-style transmitter: captures L/R/fmt once per frame and shifts them out MSB-first
// with registered BCK, LRCK, DATA and the next_sample pacing strobe.
module audio_i2s_tx
   import audio_i2s_tx_pkg::*;
#(
   parameter int unsigned SAMPLE_W     = AUDIO_SAMPLE_W,
   parameter int unsigned BCK_DIV_LOG2 = 3,
   parameter int unsigned SLOT_BITS    = AUDIO_SLOT_BITS
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SAMPLE_W-1:0] left_audio,
   input  logic [SAMPLE_W-1:0] right_audio,
   input  logic [1:0]          fmt,
   output logic                next_sample,
   output logic                i2s_bck,
   output logic                i2s_lrck,
   output logic                i2s_data
);

   localparam int unsigned BIT_W = $clog2(SLOT_BITS);

   logic             bck;
   logic [BIT_W-1:0] bit_idx;
   logic             chan;
   logic             frame_start;
   logic             frame_end;

   audio_frame_timer #(
      .BCK_DIV_LOG2 (BCK_DIV_LOG2),
      .SLOT_BITS    (SLOT_BITS)
   ) u_frame_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .bck         (bck),
      .bit_idx     (bit_idx),
      .chan        (chan),
      .frame_start (frame_start),
      .frame_end   (frame_end)
   );

   logic [SAMPLE_W-1:0] left_q;
   logic [SAMPLE_W-1:0] right_q;
   audio_fmt_e          fmt_q;
   logic                next_sample_q;
   logic                bck_q;
   logic                lrck_q;
   logic                data_q;
   logic                slot_bit;

   always_comb begin
      slot_bit = fmt_bit(chan ? right_q : left_q, fmt_q, bit_idx);
   end

   // Outputs are decoded from the current count and registered, so all four share one
   // cycle of lag. The hold registers load on the last cycle of a frame so the whole next
   // frame uses a single sample pair and format.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         left_q        <= '0;
         right_q       <= '0;
         fmt_q         <= FMT_MUTE;
         next_sample_q <= 1'b0;
         bck_q         <= 1'b0;
         lrck_q        <= 1'b0;
         data_q        <= 1'b0;
      end else begin
         if (frame_end) begin
            left_q  <= left_audio;
            right_q <= right_audio;
            fmt_q   <= audio_fmt_e'(fmt);
         end
         next_sample_q <= frame_start;
         bck_q         <= bck;
         lrck_q        <= chan;
         data_q        <= slot_bit;
      end
   end

   assign next_sample = next_sample_q;
   assign i2s_bck     = bck_q;
   assign i2s_lrck    = lrck_q;
   assign i2s_data    = data_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Scoreboarded bench for audio_i2s_tx: expected frames are queued as stimulus is applied and
// checked by a BCK-rising-edge deserializer; next_sample spacing is checked independently.
module tb_audio_i2s_tx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] left_audio = '0;
   logic [15:0] right_audio = '0;
   logic [1:0]  fmt = 2'd0;
   logic        next_sample;
   logic        i2s_bck;
   logic        i2s_lrck;
   logic        i2s_data;

   always #20 clk = ~clk;

   audio_i2s_tx #(
      .SAMPLE_W     (16),
      .BCK_DIV_LOG2 (3),
      .SLOT_BITS    (32)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .left_audio  (left_audio),
      .right_audio (right_audio),
      .fmt         (fmt),
      .next_sample (next_sample),
      .i2s_bck     (i2s_bck),
      .i2s_lrck    (i2s_lrck),
      .i2s_data    (i2s_data)
   );

   typedef struct packed {
      logic [1:0]  f;
      logic [15:0] l;
      logic [15:0] r;
   } frame_t;

   frame_t sb[$];
   int     n_vec = 0;
   int     n_err = 0;
   bit     at_pulse = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // 32-bit slot image, slot bit 0 in the MSB (order of arrival on the wire).
   function automatic logic [31:0] exp_slot(input logic [1:0] f, input logic [15:0] s);
      case (f)
         2'd0:    return {1'b0, s, 15'b0};
         2'd1:    return {s, 16'b0};
         2'd2:    return {16'b0, s};
         default: return 32'b0;
      endcase
   endfunction

   task automatic push_exp(input logic [1:0] f, input logic [15:0] l, input logic [15:0] r);
      frame_t e;
      e.f = f;
      e.l = l;
      e.r = r;
      sb.push_back(e);
   endtask

   // Monitor: deserializer plus next_sample spacing/alignment.
   initial begin
      logic        prev_bck;
      logic [31:0] lsr;
      logic [31:0] rsr;
      int          lcnt;
      int          rcnt;
      int          since;
      bit          first_pulse;
      frame_t      e;
      prev_bck = 1'b0; lsr = '0; rsr = '0; lcnt = 0; rcnt = 0; since = 0; first_pulse = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_bck = 1'b0; lcnt = 0; rcnt = 0; since = 0; first_pulse = 1'b1;
         end else begin
            since++;
            if (next_sample) begin
               if (!first_pulse) check_eq("ns_period", since, 512);
               check_eq("ns_align_bck_lrck", {30'b0, i2s_bck, i2s_lrck}, 32'd0);
               first_pulse = 1'b0;
               since = 0;
            end
            if (i2s_bck && !prev_bck) begin
               if (!i2s_lrck) begin
                  lsr = {lsr[30:0], i2s_data};
                  lcnt++;
               end else begin
                  rsr = {rsr[30:0], i2s_data};
                  rcnt++;
               end
               if (rcnt == 32) begin
                  check_eq("left_slot_bits", lcnt, 32);
                  check_eq("sb_nonempty", {31'b0, sb.size() > 0}, 32'd1);
                  if (sb.size() > 0) begin
                     e = sb.pop_front();
                     check_eq("left_slot", lsr, exp_slot(e.f, e.l));
                     check_eq("right_slot", rsr, exp_slot(e.f, e.r));
                  end
                  lcnt = 0;
                  rcnt = 0;
               end
            end
            prev_bck = i2s_bck;
         end
      end
   end

   task automatic wait_pulse();
      if (at_pulse) begin
         at_pulse = 1'b0;
         return;
      end
      for (int i = 0; i < 600; i++) begin
         @(posedge clk);
         #1;
         if (next_sample) return;
      end
      check_eq("ns_timeout", {31'b0, next_sample}, 32'd1);
   endtask

   // Reset for n edges; the first frame afterwards must be muted.
   task automatic do_reset(input int n);
      rst_n = 1'b0;
      sb.delete();
      push_exp(2'd3, 16'h0, 16'h0);
      repeat (n) @(posedge clk);
      #1;
      check_eq("rst_next_sample", {31'b0, next_sample}, 32'd0);
      check_eq("rst_bck", {31'b0, i2s_bck}, 32'd0);
      check_eq("rst_lrck", {31'b0, i2s_lrck}, 32'd0);
      check_eq("rst_data", {31'b0, i2s_data}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("ns_first_after_rst", {31'b0, next_sample}, 32'd1);
      at_pulse = 1'b1;
   endtask

   // At a frame start, queue what the next frame must carry, then present it after dly cycles.
   task automatic apply_frame(input logic [15:0] l, input logic [15:0] r, input logic [1:0] f,
                              input int dly);
      wait_pulse();
      push_exp(f, l, r);
      if (dly > 0) begin
         repeat (dly) @(posedge clk);
         #1;
      end
      left_audio  = l;
      right_audio = r;
      fmt         = f;
   endtask

   initial begin
      left_audio  = 16'hDEAD;
      right_audio = 16'hBEEF;
      fmt         = 2'd0;
      do_reset(3);
      apply_frame(16'hA5C3, 16'h8001, 2'd0, 0);
      apply_frame(16'hA5C3, 16'h8001, 2'd1, 0);
      apply_frame(16'hA5C3, 16'h8001, 2'd2, 0);
      apply_frame(16'h1234, 16'h5A5A, 2'd0, 0);
      // Left changes mid-frame: current frame keeps 1234, next carries FFFF.
      apply_frame(16'hFFFF, 16'h5A5A, 2'd0, 100);
      // Format switches to mute mid-frame: current frame stays I2S.
      apply_frame(16'hFFFF, 16'h5A5A, 2'd3, 200);
      apply_frame(16'h8000, 16'h7FFF, 2'd1, 0);
      apply_frame(16'h0001, 16'hFFFE, 2'd2, 0);
      for (int i = 0; i < 4; i++) begin
         apply_frame(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)),
                     int'($urandom_range(0, 400)));
      end
      // Abort a frame at cnt=300 with a one-cycle reset.
      wait_pulse();
      repeat (299) @(posedge clk);
      #1;
      do_reset(1);
      apply_frame(16'hC001, 16'h0FF0, 2'd0, 0);
      apply_frame(16'h0001, 16'h0002, 2'd2, 0);
      wait_pulse();
      check_eq("sb_drained", sb.size(), 32'd1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Serial audio transmitter directly downstream of the PCM playback stage. It owns the audio frame timebase and issues the one-cycle `next_sample` strobe that paces the PCM sample-rate accumulator. Once per frame it captures the 16-bit left/right words and serializes them MSB-first to an external stereo DAC over a 3-wire I2S-style link (BCK, LRCK, DATA), with a selectable frame format.

## Interface
Parameters:
- `SAMPLE_W`, 16, width of the audio words; fixed at 16 in this revision.
- `BCK_DIV_LOG2`, 3, log2 of clk cycles per BCK period (8).
- `SLOT_BITS`, 32, BCK periods per channel slot.

Ports:
- `clk` in 1: system clock, 25 MHz.
- `rst_n` in 1: reset, synchronous, active-low.
- `left_audio` in 16: signed left sample from the PCM stage.
- `right_audio` in 16: signed right sample from the PCM stage.
- `fmt` in 2: frame format. 0 = I2S, 1 = left-justified, 2 = right-justified, 3 = mute (all-zero data, clocks running).
- `next_sample` out 1: one-cycle strobe, once per frame.
- `i2s_bck` out 1: bit clock.
- `i2s_lrck` out 1: word select. 0 = left slot, 1 = right slot.
- `i2s_data` out 1: serial data.

## Operation
- Frame counter `cnt` is 9 bits (2 × 32 × 8 = 512 clk per frame, 48.828 kHz at 25 MHz).
  - It increments every cycle and wraps 511→0.
  - Field decode: `cnt[2:0]` = phase within BCK, `cnt[7:3]` = bit index b (0..31), `cnt[8]` = channel.
- Capture: in the cycle where `cnt`==511, register `left_audio`, `right_audio` and `fmt` into hold registers. The hold registers are used for the entire following frame. Input changes at any other time are ignored.
- Data bit for hold sample s at bit index b:
  - I2S: b=1..16 → s[16−b]; b=0 and b=17..31 → 0.
  - Left-justified: b=0..15 → s[15−b]; otherwise 0.
  - Right-justified: b=16..31 → s[31−b]; otherwise 0.
  - Mute: 0.
- Slot source: left hold sample when `cnt[8]`=0, right hold sample when `cnt[8]`=1.
- `i2s_bck` is 0 for phases 0..3 and 1 for phases 4..7. Data therefore changes on the BCK falling edge and is stable at the BCK rising edge.
- `next_sample` asserts for the single cycle that corresponds to `cnt`==0.

## Timing
- All outputs are registered. Output value in cycle t is decoded from `cnt` in cycle t−1, so all four outputs share the same one-cycle lag and remain mutually aligned.
- Reset (`rst_n`=0 at a clock edge) clears:
  - `cnt`, all hold registers, and every output to 0.
  - `fmt` hold resets to mute, so the first frame after reset carries zero data.
- Reset mid-frame aborts the frame immediately. There is no partial-frame completion.
- First edge with `rst_n`=1 sees `cnt`=0, so `next_sample` is 1 in the following cycle. After that it pulses every 512 cycles exactly.
- Latency: `next_sample` pulse to capture is 511 cycles. The upstream stage must present stable samples within that window; the PCM stage needs ≤10 cycles.
- Samples captured at the end of frame k−1 appear in frame k. Left MSB in I2S mode starts at the cycle decoded from `cnt`=8.
- `fmt` changes take effect only at the next frame boundary. There is never a mixed-format frame.
- LRCK transitions coincide with BCK falling edges (`cnt[2:0]`==0).

## Structure
- Shared audio package holds:
  - `FMT_I2S`=0, `FMT_LJ`=1, `FMT_RJ`=2, `FMT_MUTE`=3.
  - `AUDIO_FRAME_CLKS`=512.
  - `AUDIO_SAMPLE_W`=16.
- One sub-module is natural: `audio_frame_timer`. It holds `cnt` and decodes phase, bit index, channel and the `next_sample` strobe. It is reusable by any future audio sink.
- The top level contains the hold registers, the bit-select mux and the output registers.

## Test plan
- Reset release -> all outputs 0; `next_sample` pulses in cycle 1, then again in cycles 513 and 1025; no other pulses.
- `fmt`=0, L=16'hA5C3, R=16'h8001 held -> deserializer on BCK rising edges, bits 1..16 of each slot, reads 16'hA5C3 (LRCK=0) and 16'h8001 (LRCK=1); bits 0 and 17..31 read 0.
- `fmt`=1, then `fmt`=2, same samples -> the word appears at b=0..15 and at b=16..31 respectively; all other bits 0.
- Change `left_audio` from 16'h1234 to 16'hFFFF at `cnt`=100 -> current frame still sends 16'h1234; next frame sends 16'hFFFF.
- Switch `fmt` 0→3 mid-frame -> remainder of the current frame stays I2S; the next frame has DATA=0 while BCK and LRCK keep toggling.
- Assert `rst_n`=0 for one cycle at `cnt`=300 -> outputs 0 the next cycle; frame restarts with a `next_sample` pulse one cycle after release; the first frame is muted.
